// File: rtl/axi_m_single.sv
// axi_m_single: single-outstanding AXI initiator turning one-word host commands into AW/W/B or AR/R transactions.
// Defining AXI_M_TIMEOUT_EN adds a per-transaction watchdog that completes with resp 2'b11.
module axi_m_single #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [31:0]       wdata_o,
    output logic [3:0]        wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [31:0]       rdata_i,
    input  logic              rvalid_i,
    output logic              rready_o
);
    typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, DONE} state_t;
    state_t            state_q;
    logic              cmd_ready_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        resp_q;
`ifdef AXI_M_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             expired;
    assign expired = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign awaddr_o  = addr_q;
    assign araddr_o  = addr_q;
    assign awvalid_o = awvalid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
`ifdef AXI_M_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    cmd_ready_q <= 1'b0;
                    addr_q      <= cmd_addr;
                    wdata_q     <= cmd_wdata;
                    wstrb_q     <= cmd_wstrb;
                    awvalid_q   <= cmd_write;
                    wvalid_q    <= cmd_write;
                    arvalid_q   <= !cmd_write;
                    state_q     <= cmd_write ? WR : RD;
`ifdef AXI_M_TIMEOUT_EN
                    cnt_q       <= '0;
`endif
                end
                WR: begin
                    // AW and W complete independently; leave once both are done or finishing now
                    awvalid_q <= awvalid_q && !awready_i;
                    wvalid_q  <= wvalid_q && !wready_i;
                    if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
                        bready_q <= 1'b1;
                        state_q  <= WRESP;
                    end
                end
                WRESP: if (bvalid_i) begin
                    bready_q    <= 1'b0;
                    resp_q      <= bresp_i;
                    rdata_q     <= '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                RD: if (arready_i) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= RDATA;
                end
                RDATA: if (rvalid_i) begin
                    rready_q    <= 1'b0;
                    rdata_q     <= rdata_i;
                    resp_q      <= 2'b00;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef AXI_M_TIMEOUT_EN
            // The watchdog overrides whatever the slave did this cycle
            if (state_q inside {WR, WRESP, RD, RDATA}) begin
                cnt_q <= cnt_q + 1'b1;
                if (expired) begin
                    awvalid_q   <= 1'b0;
                    wvalid_q    <= 1'b0;
                    bready_q    <= 1'b0;
                    arvalid_q   <= 1'b0;
                    rready_q    <= 1'b0;
                    resp_q      <= 2'b11;
                    rdata_q     <= '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_axi_m_single.sv
// tb_axi_m_single: randomized self-checking bench with a delay-configurable AXI slave and a
// memory/latency reference model computed from the transaction rules.
module tb_axi_m_single;
    localparam int AW = 32;
    localparam int TO = 256;

    logic clk = 1'b0, areset = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0] cmd_wstrb = '0;
    logic rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [AW-1:0] awaddr_o, araddr_o;
    logic awvalid_o, awready_i = 1'b0;
    logic [31:0] wdata_o;
    logic [3:0] wstrb_o;
    logic wvalid_o, wready_i = 1'b0;
    logic [1:0] bresp_i = 2'b00;
    logic bvalid_i = 1'b0, bready_o;
    logic arvalid_o, arready_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic rvalid_i = 1'b0, rready_o;

    always #5 clk = ~clk;

    axi_m_single #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // slave configuration: cycles of visible valid before ready, cycles before response
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0] slv_bresp = 2'b00;
    bit no_proto = 0;

    logic [31:0] slv_mem [bit [31:0]];
    logic [31:0] ref_mem [bit [31:0]];
    bit got_aw, got_w, b_pend, r_pend;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0] s_wstrb;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_hs_cyc, w_hs_cyc;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0] p_wstrb;

    // Slave acts at negedges; handshakes of the previous posedge are resolved from the last snapshot
    initial forever begin
        @(negedge clk);
        if (!areset) begin
            awready_i = 0; wready_i = 0; arready_i = 0; bvalid_i = 0; rvalid_i = 0;
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr} = '0;
        end else begin
            if (!no_proto) begin
                if (p_awv && !p_awr) begin
                    checks++;
                    if (awvalid_o !== 1'b1 || awaddr_o !== p_awaddr) begin
                        errors++;
                        $display("FAIL aw_hold awvalid=%b awaddr=%h expected 1/%h", awvalid_o, awaddr_o, p_awaddr);
                    end
                end
                if (p_wv && !p_wr) begin
                    checks++;
                    if (wvalid_o !== 1'b1 || wdata_o !== p_wdata || wstrb_o !== p_wstrb) begin
                        errors++;
                        $display("FAIL w_hold wvalid=%b wdata=%h wstrb=%h expected 1/%h/%h", wvalid_o, wdata_o, wstrb_o, p_wdata, p_wstrb);
                    end
                end
                if (p_arv && !p_arr) begin
                    checks++;
                    if (arvalid_o !== 1'b1 || araddr_o !== p_araddr) begin
                        errors++;
                        $display("FAIL ar_hold arvalid=%b araddr=%h expected 1/%h", arvalid_o, araddr_o, p_araddr);
                    end
                end
            end
            if (p_awv && p_awr) begin got_aw = 1; s_awaddr = p_awaddr; aw_hs_cyc = cyc; end
            if (p_wv && p_wr) begin got_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; w_hs_cyc = cyc; end
            if (p_bv && p_br) bvalid_i = 0;
            if (p_rv && p_rr) rvalid_i = 0;
            if (p_arv && p_arr) begin r_pend = 1; r_cnt = r_dly; s_araddr = p_araddr; end
            if (got_aw && got_w) begin
                logic [31:0] cur;
                cur = slv_mem.exists(s_awaddr) ? slv_mem[s_awaddr] : '0;
                for (int i = 0; i < 4; i++) if (s_wstrb[i]) cur[8*i +: 8] = s_wdata[8*i +: 8];
                slv_mem[s_awaddr] = cur;
                got_aw = 0; got_w = 0; b_pend = 1; b_cnt = b_dly;
            end
            if (b_pend) begin
                if (b_cnt == 0) begin bvalid_i = 1; bresp_i = slv_bresp; b_pend = 0; end
                else b_cnt--;
            end
            if (r_pend) begin
                if (r_cnt == 0) begin
                    rvalid_i = 1;
                    rdata_i = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : '0;
                    r_pend = 0;
                end else r_cnt--;
            end
            aw_cnt = awvalid_o ? aw_cnt + 1 : 0;
            w_cnt  = wvalid_o ? w_cnt + 1 : 0;
            ar_cnt = arvalid_o ? ar_cnt + 1 : 0;
            awready_i = awvalid_o && aw_cnt > aw_dly;
            wready_i  = wvalid_o && w_cnt > w_dly;
            arready_i = arvalid_o && ar_cnt > ar_dly;
            p_awv = awvalid_o; p_awr = awready_i; p_awaddr = awaddr_o;
            p_wv = wvalid_o; p_wr = wready_i; p_wdata = wdata_o; p_wstrb = wstrb_o;
            p_arv = arvalid_o; p_arr = arready_i; p_araddr = araddr_o;
            p_bv = bvalid_i; p_br = bready_o; p_rv = rvalid_i; p_rr = rready_o;
        end
    end

    function automatic void ref_write(input logic [31:0] a, d, input logic [3:0] s);
        logic [31:0] mask, old;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        old = ref_mem.exists(a) ? ref_mem[a] : '0;
        ref_mem[a] = (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // Called at a negedge; returns at the negedge where rsp_valid is first seen (lat counts edges from acceptance)
    task automatic issue(input bit wr, input logic [31:0] a, d, input logic [3:0] s, output int lat);
        int n;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
    endtask

    task automatic ack;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++;
        if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_handshakes got %b want 000000", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid});
        end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || awaddr_o !== '0 || wdata_o !== 32'h0 || wstrb_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_regs rdata=%h resp=%b awaddr=%h wdata=%h wstrb=%h want all 0", rsp_rdata, rsp_resp, awaddr_o, wdata_o, wstrb_o);
        end
        areset = 1;
        @(negedge clk);
    endtask

    task automatic test_write_basic;
        int lat;
        issue(1, 32'h3, 32'hDEADBEEF, 4'hF, lat);
        ref_write(32'h3, 32'hDEADBEEF, 4'hF);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
        checks++;
        if (aw_hs_cyc != w_hs_cyc) begin errors++; $display("FAIL wr_aw_w_same_cycle aw=%0d w=%0d want equal", aw_hs_cyc, w_hs_cyc); end
        checks++;
        if (rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL wr_rsp resp=%b rdata=%h want 00/0", rsp_resp, rsp_rdata);
        end
        ack;
    endtask

    task automatic test_wready_delay;
        int lat;
        logic [31:0] d;
        d = $urandom;
        w_dly = 4;
        issue(1, 32'h10, d, 4'hF, lat);
        ref_write(32'h10, d, 4'hF);
        checks++;
        if (w_hs_cyc - aw_hs_cyc != 4) begin errors++; $display("FAIL wdly_gap got %0d want 4", w_hs_cyc - aw_hs_cyc); end
        checks++;
        if (lat != 7 || rsp_resp !== 2'b00) begin errors++; $display("FAIL wdly_rsp lat=%0d resp=%b want 7/00", lat, rsp_resp); end
        ack;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL wdly_single_rsp rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
        end
        w_dly = 0;
    endtask

    task automatic test_read_hold;
        int lat;
        issue(0, 32'h3, 32'h0, 4'h0, lat);
        checks++;
        if (lat != 3 || rsp_rdata !== 32'hDEADBEEF || rsp_resp !== 2'b00) begin
            errors++; $display("FAIL rd_basic lat=%0d rdata=%h resp=%b want 3/deadbeef/00", lat, rsp_rdata, rsp_resp);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || cmd_ready !== 1'b0) begin
                errors++; $display("FAIL rd_hold rsp_valid=%b rdata=%h cmd_ready=%b want 1/deadbeef/0", rsp_valid, rsp_rdata, cmd_ready);
            end
        end
        ack;
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [31:0] a, d;
        a = 32'h20; d = $urandom;
        issue(1, a, d, 4'h5, lat);
        ref_write(a, d, 4'h5);
        rsp_ready = 1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = a;
        @(negedge clk);
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_idle rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 0;
        checks++;
        if (cmd_ready !== 1'b0 || arvalid_o !== 1'b1) begin
            errors++; $display("FAIL b2b_accept cmd_ready=%b arvalid=%b want 0/1", cmd_ready, arvalid_o);
        end
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== ref_read(a)) begin
            errors++; $display("FAIL b2b_read rsp_valid=%b rdata=%h want 1/%h", rsp_valid, rsp_rdata, ref_read(a));
        end
        ack;
    endtask

    task automatic test_reset_wresp;
        int n;
        logic [31:0] d;
        d = $urandom;
        b_dly = 100000;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = d; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!bready_o && n < 20) begin @(negedge clk); n++; end
        ref_write(32'h30, d, 4'hF);
        no_proto = 1;
        areset = 0;
        #1;
        checks++;
        if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid} !== 6'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_wresp handshakes=%b cmd_ready=%b want 000000/1",
                {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid}, cmd_ready);
        end
        repeat (2) @(negedge clk);
        b_dly = 0;
        areset = 1;
        no_proto = 0;
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat, exp_lat, a_d, w_d;
        bit wr;
        logic [31:0] a, d, exp_rd;
        logic [3:0] s;
        logic [1:0] exp_rs;
        for (int i = 0; i < 40; i++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            wr = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 7)) << 2;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            slv_bresp = $urandom_range(0, 1) ? 2'b10 : 2'b00;
            a_d = aw_dly; w_d = w_dly;
            exp_lat = wr ? 3 + (a_d > w_d ? a_d : w_d) + b_dly : 3 + ar_dly + r_dly;
            exp_rd = wr ? 32'h0 : ref_read(a);
            exp_rs = wr ? slv_bresp : 2'b00;
            issue(wr, a, d, s, lat);
            checks++;
            if (lat != exp_lat || rsp_rdata !== exp_rd || rsp_resp !== exp_rs) begin
                errors++; $display("FAIL rand_%0d wr=%0b addr=%h lat=%0d rdata=%h resp=%b want %0d/%h/%b",
                    i, wr, a, lat, rsp_rdata, rsp_resp, exp_lat, exp_rd, exp_rs);
            end
            if (wr) ref_write(a, d, s);
            ack;
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0; slv_bresp = 2'b00;
    endtask

`ifdef AXI_M_TIMEOUT_EN
    task automatic test_timeout;
        int lat;
        ar_dly = 100000;
        no_proto = 1;
        issue(0, 32'h4, 32'h0, 4'h0, lat);
        checks++;
        if (lat != TO + 1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'h0 || arvalid_o !== 1'b0) begin
            errors++; $display("FAIL timeout lat=%0d resp=%b rdata=%h arvalid=%b want %0d/11/0/0", lat, rsp_resp, rsp_rdata, arvalid_o, TO + 1);
        end
        ack;
        ar_dly = 0;
        no_proto = 0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_write_basic;
        test_wready_delay;
        test_read_hold;
        test_back_to_back;
        test_reset_wresp;
        test_random;
`ifdef AXI_M_TIMEOUT_EN
        test_timeout;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
